dmem_bridge: RTL
================

# dmem_bridge

Data-side memory responder sitting between the MEM stage and the external SRAM-like data bus. It accepts the MEM stage's per-cycle access request (read enable, byte write enables, address, write data, size), stalls the pipeline, and runs one bus transaction through an address/data handshake. It then returns the read word to the MEM stage's `dcache_data_i` input. One outstanding transaction at most; exception flushes cancel cleanly without corrupting the bus protocol.

## Interface
- No parameters.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_ce_i`  in  1  read request from MEM stage.
- `mem_we_i`  in  4  byte write enables from MEM stage; nonzero = write request.
- `mem_addr_i`  in  32  physical byte address.
- `mem_data_i`  in  32  write data, already lane-aligned.
- `r_size_i`  in  3  read size: 000 byte, 001 half, 010 word.
- `clear_i`  in  1  exception/flush in MEM this cycle.
- `pipe_stall_i`  in  1  pipeline held by another source.
- `dcache_data_o`  out  32  read word returned to MEM stage.
- `stall_o`  out  1  hold pipeline; access not complete.
- `data_req`  out  1  bus request valid.
- `data_wr`  out  1  1 = write, 0 = read.
- `data_size`  out  2  00 byte, 01 half, 10 word.
- `data_addr`  out  32  bus address.
- `data_wdata`  out  32  bus write data.
- `data_wstrb`  out  4  bus byte strobes (0000 on reads).
- `data_addr_ok`  in  1  request accepted this cycle.
- `data_data_ok`  in  1  response (read data or write ack) this cycle.
- `data_rdata`  in  32  read data, valid with `data_data_ok`.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset -> IDLE; all outputs 0, internal cancel flag 0.
- IDLE: access = `mem_ce_i | (|mem_we_i)`, qualified by `!clear_i`. If an access is present:
  - `stall_o` = 1 combinationally in the same cycle.
  - Latch the request fields; go to REQ.
  - Write wins if both `mem_ce_i` and `mem_we_i` are set; this is not a legal stage output.
- Request formation, latched on entry to REQ:
  - Read size = `r_size_i[1:0]`. Word reads force `addr[1:0]=00`; this serves LWL/LWR at unaligned addresses.
  - Write size from strobes: 0001/0010/0100/1000 -> byte at the original address. 0011/1100 -> half. Anything else (1111, 1110, 0111) -> word with `addr[1:0]=00`.
  - `data_wdata` = `mem_data_i` unchanged. `data_wstrb` = `mem_we_i`.
- REQ: `data_req` = 1; all `data_*` fields held stable. On `data_addr_ok` -> WAIT, and `data_req` drops the next cycle. The request is never withdrawn before `data_addr_ok`.
- WAIT: `data_req` = 0. On `data_data_ok`:
  - Reads latch `data_rdata` into `dcache_data_o`.
  - If the cancel flag is set: clear the flag, go to IDLE.
  - Otherwise go to DONE.
- DONE: `stall_o` = 0 and `dcache_data_o` is valid.
  - If `pipe_stall_i`: stay in DONE; the same instruction is still present and must not reissue.
  - Otherwise go to IDLE on the next edge.
- `stall_o` = 1 in REQ and WAIT, plus the IDLE launch cycle; 0 otherwise.
- `clear_i` while in REQ or WAIT sets the cancel flag. The transaction still completes on the bus, but no DONE cycle occurs and read data is discarded. `stall_o` stays 1 until the final `data_data_ok` cycle; it is 0 in the following IDLE.
- `dcache_data_o` holds its last value outside DONE. After a write it is unchanged.

## Timing
- Minimum access, with `addr_ok` in the first REQ cycle and `data_ok` one cycle later:
  - T0 IDLE launch, stall = 1.
  - T1 REQ, req = 1.
  - T2 WAIT.
  - T3 DONE, stall = 0.
  - Pipeline stalls 3 cycles.
- `data_addr_ok` and `data_data_ok` may arrive in the same cycle only in WAIT. A `data_data_ok` arriving in REQ is ignored: one outstanding request only.
- Back-to-back accesses: the next access launches in the IDLE cycle after DONE, so there is no bubble beyond that.
- `rst` asserted mid-transaction forces IDLE immediately, drops `data_req` and `stall_o`, and clears the cancel flag. The bus is reset alongside.

## Test plan
- LW at 0x8000_0010, `addr_ok` on T1, `data_ok` on T2 with 0xDEADBEEF -> req/wr/size/addr = 1/0/10/0x8000_0010; `dcache_data_o` = 0xDEADBEEF in T3; `stall_o` = 1,1,1,0.
- SB, `mem_we_i`=0100, addr 0x...0006, data 0x5A5A5A5A -> `data_size`=00, `data_addr`=0x...0006, `data_wstrb`=0100, `data_wr`=1; `dcache_data_o` unchanged.
- SWL, `mem_we_i`=1110, addr 0x...0001; and LWR, addr 0x...0003 -> both `data_size`=10 with address 0x...0000.
- `addr_ok` delayed 4 cycles -> `data_req` and all fields stable throughout; `stall_o` held.
- `clear_i` pulse in WAIT, then `data_ok` -> no DONE cycle, FSM returns to IDLE, `dcache_data_o` not updated. A `clear_i` in IDLE with `mem_ce_i`=1 -> no request issued.
- `rst` low during WAIT -> `data_req`=0, `stall_o`=0 immediately. After release, a fresh LW completes normally.

Source files
------------

// File: rtl/dmem_bridge.sv
// dmem_bridge: MEM-stage data access responder. Launches one bus transaction
// per access through an addr/data handshake, stalls the pipeline meanwhile,
// and returns read data on dcache_data_o. Flushes cancel cleanly.
module dmem_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic [3:0]  mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [2:0]  r_size_i,
  input  logic        clear_i,
  input  logic        pipe_stall_i,
  output logic [31:0] dcache_data_o,
  output logic        stall_o,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic        cancel_q, cancel_d;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;

  logic        access;
  logic        launch;
  logic        is_wr;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic        cancel_now;

  // Request decode: write wins over read; word accesses are word-aligned
  always_comb begin
    access   = (mem_ce_i | (|mem_we_i)) & ~clear_i;
    launch   = (state_q == IDLE) & access;
    is_wr    = |mem_we_i;
    req_addr = mem_addr_i;
    req_size = 2'b10;
    if (is_wr) begin
      unique case (mem_we_i)
        4'b0001, 4'b0010, 4'b0100, 4'b1000: req_size = 2'b00;
        4'b0011, 4'b1100:                   req_size = 2'b01;
        default:                            req_size = 2'b10;
      endcase
    end else begin
      req_size = r_size_i[1:0];
    end
    if (req_size == 2'b10) req_addr[1:0] = 2'b00;
    // A flush arriving in the data_ok cycle itself also discards the result
    cancel_now = cancel_q | clear_i;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and cancel-flag logic
  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    unique case (state_q)
      IDLE: if (launch) state_d = REQ;
      REQ: begin
        if (clear_i)      cancel_d = 1'b1;
        if (data_addr_ok) state_d  = WAIT;
      end
      WAIT: begin
        if (clear_i) cancel_d = 1'b1;
        if (data_data_ok) begin
          cancel_d = 1'b0;
          state_d  = cancel_now ? IDLE : DONE;
        end
      end
      DONE: if (!pipe_stall_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request field latch, cancel flag and returned read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cancel_q <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
    end else begin
      cancel_q <= cancel_d;
      if (launch) begin
        wr_q    <= is_wr;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= mem_data_i;
        wstrb_q <= is_wr ? mem_we_i : 4'b0000;
      end
      if (state_q == WAIT && data_data_ok && !wr_q && !cancel_now)
        rdata_q <= data_rdata;
    end
  end

  // Outputs
  always_comb begin
    data_req      = (state_q == REQ);
    data_wr       = wr_q;
    data_size     = size_q;
    data_addr     = addr_q;
    data_wdata    = wdata_q;
    data_wstrb    = wstrb_q;
    dcache_data_o = rdata_q;
    stall_o       = launch | (state_q == REQ) | (state_q == WAIT);
  end

endmodule
